// File: rtl/gelato_pkg.sv
// rtl/gelato_pkg.sv - shared types and helpers for the Gelato icache miss controller
`timescale 1ns/1ps
package gelato_pkg;
  // Entry fields are sized for the widest supported configuration; the controller
  // zero-extends on write and truncates on read.
  localparam int MAX_LINE_W = 32;
  localparam int MAX_WARPS  = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } refill_state_e;

  typedef struct packed {
    logic                  valid;
    logic [MAX_LINE_W-1:0] line;
    logic [MAX_WARPS-1:0]  mask;
  } miss_entry_t;

  function automatic int line_offset(input int words_per_line);
    return $clog2(words_per_line * 4);
  endfunction
endpackage

// File: rtl/gelato_icache_miss_fifo.sv
// rtl/gelato_icache_miss_fifo.sv - allocation-order queue of miss entry indices
`timescale 1ns/1ps
module gelato_icache_miss_fifo #(
  parameter int  DEPTH = 4,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [IDX_W-1:0] push_idx,
  input  logic             pop,
  output logic             empty,
  output logic [IDX_W-1:0] head,
  output logic [IDX_W:0]   count
);
  logic [IDX_W-1:0] slots [DEPTH];
  logic [IDX_W-1:0] rd_ptr;
  logic [IDX_W-1:0] wr_ptr;

  // Occupancy never exceeds DEPTH: every queued index owns a distinct entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        slots[wr_ptr] <= push_idx;
        wr_ptr        <= wr_ptr + IDX_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + IDX_W'(1);
      if (push && !pop)      count <= count + (IDX_W+1)'(1);
      else if (pop && !push) count <= count - (IDX_W+1)'(1);
    end
  end

  assign empty = (count == '0);
  assign head  = slots[rd_ptr];
endmodule

// File: rtl/gelato_icache_miss_controller.sv
// rtl/gelato_icache_miss_controller.sv - L1 icache miss merge table and line refill sequencer
`timescale 1ns/1ps
module gelato_icache_miss_controller
  import gelato_pkg::*;
#(
  parameter int  ADDR_WIDTH     = 32,
  parameter int  NUM_WARPS      = 8,
  parameter int  NUM_ENTRIES    = 4,
  parameter int  WORDS_PER_LINE = 4,
  localparam int LOFF   = line_offset(WORDS_PER_LINE),
  localparam int LINE_W = ADDR_WIDTH - LOFF,
  localparam int WID_W  = $clog2(NUM_WARPS),
  localparam int IDX_W  = $clog2(NUM_ENTRIES),
  localparam int BEAT_W = $clog2(WORDS_PER_LINE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rdy,
  input  logic                  miss_valid,
  output logic                  miss_ready,
  input  logic [LINE_W-1:0]     miss_line_addr,
  input  logic [WID_W-1:0]      miss_warp_id,
  output logic                  ram_req_valid,
  input  logic                  ram_req_ready,
  output logic [ADDR_WIDTH-1:0] ram_req_addr,
  input  logic                  ram_rsp_valid,
  input  logic [31:0]           ram_rsp_data,
  output logic                  fill_valid,
  output logic [LINE_W-1:0]     fill_line_addr,
  output logic [BEAT_W-1:0]     fill_word_idx,
  output logic [31:0]           fill_data,
  output logic                  fill_last,
  output logic                  wake_valid,
  output logic [NUM_WARPS-1:0]  wake_mask
);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);

  miss_entry_t            entries [NUM_ENTRIES];
  refill_state_e          state;
  logic [BEAT_W-1:0]      beat;
  logic [IDX_W-1:0]       head_idx;
  logic [IDX_W:0]         fifo_count;
  logic                   fifo_empty;
  logic                   push;
  logic                   pop;
  logic [IDX_W-1:0]       alloc_idx;
  logic                   have_free;
  logic                   hit_done;
  logic [NUM_ENTRIES-1:0] hit_vec;
  logic [MAX_LINE_W-1:0]  req_line;
  logic [MAX_WARPS-1:0]   req_bit;
  logic [MAX_WARPS-1:0]   bypass_bit;

  assign req_line = MAX_LINE_W'(miss_line_addr);
  assign req_bit  = MAX_WARPS'(1) << miss_warp_id;

  // The entry being retired in DONE is still valid this cycle, so it is neither
  // free nor mergeable; a late miss to it rides along on the wake instead.
  always_comb begin
    hit_done  = 1'b0;
    hit_vec   = '0;
    have_free = 1'b0;
    alloc_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!entries[i].valid) begin
        have_free = 1'b1;
        alloc_idx = IDX_W'(i);
      end else if (entries[i].line == req_line) begin
        if (state == ST_DONE && IDX_W'(i) == head_idx) hit_done = 1'b1;
        else hit_vec[i] = 1'b1;
      end
    end
  end

  assign miss_ready = rst_n && rdy && miss_valid && (hit_done || (|hit_vec) || have_free);
  assign push       = miss_ready && !hit_done && !(|hit_vec);
  assign pop        = rdy && (state == ST_DONE);
  assign bypass_bit = (miss_ready && hit_done) ? req_bit : '0;

  gelato_icache_miss_fifo #(
    .DEPTH(NUM_ENTRIES)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .push_idx(alloc_idx),
    .pop     (pop),
    .empty   (fifo_empty),
    .head    (head_idx),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) entries[i] <= '0;
    end else if (rdy) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (push && alloc_idx == IDX_W'(i)) begin
          entries[i] <= '{valid: 1'b1, line: req_line, mask: req_bit};
        end else if (miss_ready && hit_vec[i]) begin
          entries[i].mask <= entries[i].mask | req_bit;
        end
        if (pop && head_idx == IDX_W'(i)) entries[i].valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      beat  <= '0;
    end else if (rdy) begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state <= ST_REQ;
            beat  <= '0;
          end
        end
        ST_REQ: begin
          if (ram_req_ready) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (ram_rsp_valid) begin
            if (beat == LAST_BEAT) begin
              state <= ST_DONE;
            end else begin
              beat  <= beat + BEAT_W'(1);
              state <= ST_REQ;
            end
          end
        end
        ST_DONE: begin
          beat  <= '0;
          state <= (fifo_count > (IDX_W+1)'(1)) ? ST_REQ : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ram_req_valid  = rdy && (state == ST_REQ);
  assign ram_req_addr   = (state == ST_REQ) ?
                          ADDR_WIDTH'({entries[head_idx].line, beat, 2'b00}) : '0;
  assign fill_valid     = rdy && (state == ST_WAIT) && ram_rsp_valid;
  assign fill_line_addr = fill_valid ? LINE_W'(entries[head_idx].line) : '0;
  assign fill_word_idx  = fill_valid ? beat : '0;
  assign fill_data      = fill_valid ? ram_rsp_data : '0;
  assign fill_last      = fill_valid && (beat == LAST_BEAT);
  assign wake_valid     = rdy && (state == ST_DONE);
  assign wake_mask      = wake_valid ? NUM_WARPS'(entries[head_idx].mask | bypass_bit) : '0;
endmodule

// File: tb/tb_gelato_icache_miss_controller.sv
// tb/tb_gelato_icache_miss_controller.sv - directed bench for the icache miss controller
`timescale 1ns/1ps
module tb_gelato_icache_miss_controller;
  localparam logic [31:0] DMASK = 32'hDEAD0000;

  logic        clk;
  logic        rst_n;
  logic        rdy;
  logic        miss_valid;
  logic        miss_ready;
  logic [27:0] miss_line_addr;
  logic [2:0]  miss_warp_id;
  logic        ram_req_valid;
  logic        ram_req_ready;
  logic [31:0] ram_req_addr;
  logic        ram_rsp_valid;
  logic [31:0] ram_rsp_data;
  logic        fill_valid;
  logic [27:0] fill_line_addr;
  logic [1:0]  fill_word_idx;
  logic [31:0] fill_data;
  logic        fill_last;
  logic        wake_valid;
  logic [7:0]  wake_mask;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit kill_rsp = 1'b0;

  logic [31:0] req_addr_q[$];
  int          req_cyc_q[$];
  logic [27:0] fill_line_q[$];
  logic [1:0]  fill_idx_q[$];
  logic [31:0] fill_data_q[$];
  logic        fill_last_q[$];
  logic [7:0]  wake_mask_q[$];
  int          wake_cyc_q[$];

  gelato_icache_miss_controller dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rdy           (rdy),
    .miss_valid    (miss_valid),
    .miss_ready    (miss_ready),
    .miss_line_addr(miss_line_addr),
    .miss_warp_id  (miss_warp_id),
    .ram_req_valid (ram_req_valid),
    .ram_req_ready (ram_req_ready),
    .ram_req_addr  (ram_req_addr),
    .ram_rsp_valid (ram_rsp_valid),
    .ram_rsp_data  (ram_rsp_data),
    .fill_valid    (fill_valid),
    .fill_line_addr(fill_line_addr),
    .fill_word_idx (fill_word_idx),
    .fill_data     (fill_data),
    .fill_last     (fill_last),
    .wake_valid    (wake_valid),
    .wake_mask     (wake_mask)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // RAM: answers one cycle after the request handshake and holds the word until consumed.
  bit          ram_fire;
  bit          ram_taken;
  logic [31:0] ram_addr;
  initial begin
    ram_rsp_valid = 1'b0;
    ram_rsp_data  = '0;
    forever begin
      @(negedge clk);
      ram_fire  = ram_req_valid && ram_req_ready;
      ram_taken = fill_valid;
      ram_addr  = ram_req_addr;
      @(posedge clk);
      #2;
      if (kill_rsp) begin
        ram_rsp_valid = 1'b0;
      end else begin
        if (ram_taken) ram_rsp_valid = 1'b0;
        if (ram_fire) begin
          ram_rsp_valid = 1'b1;
          ram_rsp_data  = ram_addr ^ DMASK;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (ram_req_valid && ram_req_ready) begin
      req_addr_q.push_back(ram_req_addr);
      req_cyc_q.push_back(cyc);
    end
    if (fill_valid) begin
      fill_line_q.push_back(fill_line_addr);
      fill_idx_q.push_back(fill_word_idx);
      fill_data_q.push_back(fill_data);
      fill_last_q.push_back(fill_last);
    end
    if (wake_valid) begin
      wake_mask_q.push_back(wake_mask);
      wake_cyc_q.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    req_addr_q.delete();
    req_cyc_q.delete();
    fill_line_q.delete();
    fill_idx_q.delete();
    fill_data_q.delete();
    fill_last_q.delete();
    wake_mask_q.delete();
    wake_cyc_q.delete();
  endtask

  task automatic do_miss(input logic [27:0] line, input logic [2:0] warp, output bit acc);
    miss_valid     = 1'b1;
    miss_line_addr = line;
    miss_warp_id   = warp;
    @(negedge clk);
    acc = miss_ready;
    tick();
    miss_valid = 1'b0;
  endtask

  task automatic wait_wakes(input int n, input int budget);
    int k = 0;
    while (wake_mask_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    tests++;
    if (wake_mask_q.size() < n) begin
      fails++;
      $display("FAIL wait_wakes got %0d wakes exp %0d", wake_mask_q.size(), n);
    end
    repeat (3) tick();
  endtask

  task automatic check_line(input string tag, input logic [27:0] line, input int t0,
                            input logic [7:0] mask);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] ea;
      ea = {line, 4'h0} + 32'(4 * i);
      tests++;
      if (i >= req_addr_q.size() || req_addr_q[i] !== ea) begin
        fails++;
        $display("FAIL %s req_addr[%0d] got %h exp %h", tag, i, req_addr_q[i], ea);
      end
      tests++;
      if (i >= fill_idx_q.size() || fill_idx_q[i] !== 2'(i) || fill_data_q[i] !== (ea ^ DMASK) ||
          fill_line_q[i] !== line || fill_last_q[i] !== (i == 3)) begin
        fails++;
        $display("FAIL %s fill[%0d] got idx %0d data %h line %h last %0b exp idx %0d data %h line %h last %0b",
                 tag, i, fill_idx_q[i], fill_data_q[i], fill_line_q[i], fill_last_q[i],
                 i, ea ^ DMASK, line, i == 3);
      end
    end
    tests++;
    if (req_addr_q.size() != 4 || fill_data_q.size() != 4) begin
      fails++;
      $display("FAIL %s counts got req %0d fill %0d exp 4 4", tag, req_addr_q.size(), fill_data_q.size());
    end
    tests++;
    if (req_cyc_q.size() < 1 || req_cyc_q[0] != t0 + 2) begin
      fails++;
      $display("FAIL %s first_req_cycle got %0d exp %0d", tag, req_cyc_q[0] - t0, 2);
    end
    tests++;
    if (wake_mask_q.size() != 1 || wake_mask_q[0] !== mask || wake_cyc_q[0] != t0 + 10) begin
      fails++;
      $display("FAIL %s wake got n %0d mask %h cyc %0d exp n 1 mask %h cyc 10",
               tag, wake_mask_q.size(), wake_mask_q[0], wake_cyc_q[0] - t0, mask);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if (miss_ready !== 1'b0 || ram_req_valid !== 1'b0 || fill_valid !== 1'b0 || wake_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_handshakes got mr %0b rq %0b fv %0b wv %0b exp 0 0 0 0",
               miss_ready, ram_req_valid, fill_valid, wake_valid);
    end
    tests++;
    if (ram_req_addr !== '0 || wake_mask !== '0 || fill_data !== '0 || fill_last !== 1'b0) begin
      fails++;
      $display("FAIL reset_data got addr %h mask %h data %h last %0b exp 0",
               ram_req_addr, wake_mask, fill_data, fill_last);
    end
    tick();
    rst_n      = 1'b1;
    miss_valid = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_single_miss();
    int t0;
    bit acc;
    clear_logs();
    t0 = cyc;
    do_miss(28'h100, 3'd2, acc);
    tests++;
    if (acc !== 1'b1) begin fails++; $display("FAIL single_accept got %0b exp 1", acc); end
    wait_wakes(1, 40);
    check_line("single", 28'h100, t0, 8'h04);
  endtask

  task automatic test_merge();
    int t0;
    bit a1, a2, a3;
    clear_logs();
    t0 = cyc;
    do_miss(28'h200, 3'd1, a1);
    repeat (2) tick();
    do_miss(28'h200, 3'd3, a2);
    repeat (2) tick();
    do_miss(28'h200, 3'd5, a3);
    tests++;
    if ({a1, a2, a3} !== 3'b111) begin fails++; $display("FAIL merge_accepts got %b exp 111", {a1, a2, a3}); end
    wait_wakes(1, 40);
    check_line("merge", 28'h200, t0, 8'h2A);
  endtask

  task automatic test_bypass();
    int t0;
    bit a1, a2;
    clear_logs();
    t0 = cyc;
    do_miss(28'h300, 3'd0, a1);
    repeat (9) tick();
    do_miss(28'h300, 3'd7, a2);
    tests++;
    if (a1 !== 1'b1 || a2 !== 1'b1) begin fails++; $display("FAIL bypass_accepts got %0b%0b exp 11", a1, a2); end
    repeat (20) tick();
    check_line("bypass", 28'h300, t0, 8'h81);
  endtask

  task automatic test_full_back_to_back();
    int t0;
    int ready_cyc;
    bit acc;
    bit all_acc;
    logic [27:0] done_lines[$];
    clear_logs();
    t0 = cyc;
    all_acc = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_miss(28'h400 + 28'(i * 'h100), 3'(i), acc);
      all_acc &= acc;
    end
    tests++;
    if (all_acc !== 1'b1) begin fails++; $display("FAIL full_first_four got %0b exp 1", all_acc); end
    miss_valid     = 1'b1;
    miss_line_addr = 28'h800;
    miss_warp_id   = 3'd4;
    ready_cyc      = -1;
    for (int k = 0; k < 40 && ready_cyc < 0; k++) begin
      @(negedge clk);
      if (miss_ready) ready_cyc = cyc;
      tick();
    end
    miss_valid = 1'b0;
    tests++;
    if (ready_cyc != t0 + 11) begin
      fails++;
      $display("FAIL full_fifth_ready_cycle got %0d exp %0d", ready_cyc - t0, 11);
    end
    wait_wakes(5, 80);
    foreach (fill_last_q[i]) if (fill_last_q[i]) done_lines.push_back(fill_line_q[i]);
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (i >= done_lines.size() || done_lines[i] !== 28'h400 + 28'(i * 'h100) ||
          wake_mask_q[i] !== 8'(1 << i)) begin
        fails++;
        $display("FAIL full_order[%0d] got line %h mask %h exp line %h mask %h",
                 i, done_lines[i], wake_mask_q[i], 28'h400 + 28'(i * 'h100), 8'(1 << i));
      end
    end
    tests++;
    if (wake_cyc_q.size() < 2 || wake_cyc_q[0] != t0 + 10 || wake_cyc_q[1] != t0 + 19) begin
      fails++;
      $display("FAIL full_wake_cycles got %0d %0d exp 10 19", wake_cyc_q[0] - t0, wake_cyc_q[1] - t0);
    end
  endtask

  task automatic test_stall_and_rdy();
    bit acc;
    clear_logs();
    ram_req_ready = 1'b0;
    do_miss(28'h900, 3'd1, acc);
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tests++;
      if (ram_req_valid !== 1'b1 || ram_req_addr !== 32'h9000) begin
        fails++;
        $display("FAIL stall_hold[%0d] got v %0b addr %h exp 1 9000", k, ram_req_valid, ram_req_addr);
      end
      tick();
    end
    ram_req_ready = 1'b1;
    tick();
    rdy            = 1'b0;
    miss_valid     = 1'b1;
    miss_line_addr = 28'hA00;
    miss_warp_id   = 3'd2;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if (fill_valid !== 1'b0 || miss_ready !== 1'b0 || ram_req_valid !== 1'b0 || wake_valid !== 1'b0) begin
        fails++;
        $display("FAIL rdy_low[%0d] got fv %0b mr %0b rq %0b wv %0b exp 0 0 0 0",
                 k, fill_valid, miss_ready, ram_req_valid, wake_valid);
      end
      tick();
    end
    miss_valid = 1'b0;
    rdy        = 1'b1;
    @(negedge clk);
    tests++;
    if (fill_valid !== 1'b1 || fill_word_idx !== 2'd0 || fill_data !== 32'hDEAD9000) begin
      fails++;
      $display("FAIL rdy_resume got fv %0b idx %0d data %h exp 1 0 deaD9000", fill_valid, fill_word_idx, fill_data);
    end
    tick();
    wait_wakes(1, 40);
    tests++;
    if (fill_data_q.size() != 4 || req_addr_q.size() != 4 || wake_mask_q[0] !== 8'h02) begin
      fails++;
      $display("FAIL stall_totals got fills %0d reqs %0d mask %h exp 4 4 02",
               fill_data_q.size(), req_addr_q.size(), wake_mask_q[0]);
    end
  endtask

  task automatic test_reset_mid_refill();
    int t1;
    bit acc;
    clear_logs();
    do_miss(28'hB00, 3'd3, acc);
    repeat (6) tick();
    #2;
    tests++;
    if (fill_valid !== 1'b1 || fill_word_idx !== 2'd2) begin
      fails++;
      $display("FAIL rst_pre got fv %0b idx %0d exp 1 2", fill_valid, fill_word_idx);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (fill_valid !== 1'b0 || ram_req_valid !== 1'b0 || wake_valid !== 1'b0 ||
        fill_data !== '0 || fill_line_addr !== '0 || ram_req_addr !== '0) begin
      fails++;
      $display("FAIL rst_async got fv %0b rq %0b wv %0b data %h line %h addr %h exp all 0",
               fill_valid, ram_req_valid, wake_valid, fill_data, fill_line_addr, ram_req_addr);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    clear_logs();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if (fill_valid !== 1'b0 || ram_req_valid !== 1'b0) begin
        fails++;
        $display("FAIL rst_stale[%0d] got fv %0b rq %0b exp 0 0", k, fill_valid, ram_req_valid);
      end
      tick();
    end
    kill_rsp = 1'b1;
    tick();
    kill_rsp = 1'b0;
    t1 = cyc;
    do_miss(28'hC00, 3'd6, acc);
    wait_wakes(1, 40);
    check_line("post_reset", 28'hC00, t1, 8'h40);
  endtask

  initial begin
    rst_n          = 1'b0;
    rdy            = 1'b1;
    miss_valid     = 1'b1;
    miss_line_addr = 28'h100;
    miss_warp_id   = 3'd0;
    ram_req_ready  = 1'b1;
    test_reset();
    test_single_miss();
    test_merge();
    test_bypass();
    test_full_back_to_back();
    test_stall_and_rdy();
    test_reset_mid_refill();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
